// File: rtl/ro_puf_engine.sv
// rtl/ro_puf_engine.sv - ring-oscillator PUF evaluator using counting windows
// Per response bit: select one oscillator per bank, count edges over a window, compare.
module ro_puf_engine #(
  parameter int NUM_RO    = 16,
  parameter int SEL_W     = 4,
  parameter int RESP_BITS = 8,
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 1024,
  parameter int SETTLE    = 16,
  parameter int MARGIN    = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
  input  logic [2*NUM_RO-1:0]          ro_in,
  output logic                         ro_enable,
  output logic                         busy,
  output logic                         done,
  output logic [RESP_BITS-1:0]         response,
  output logic [RESP_BITS-1:0]         unstable
);
  localparam int TMAX  = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam int BIT_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int CH_W  = RESP_BITS * 2 * SEL_W;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(RESP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   MARGIN_X    = (CNT_W + 1)'(MARGIN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_COMPARE,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [CH_W-1:0]      chal_q, chal_d;
  logic [CNT_W-1:0]     count_a_q, count_a_d;
  logic [CNT_W-1:0]     count_b_q, count_b_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [RESP_BITS-1:0] unst_q, unst_d;
  logic [2:0]           sync_a_q, sync_a_d;
  logic [2:0]           sync_b_q, sync_b_d;

  logic [SEL_W-1:0]  sel_a, sel_b;
  logic [NUM_RO-1:0] bank_a, bank_b;
  logic              pulse_a, pulse_b;
  logic [CNT_W:0]    cnt_a_x, cnt_b_x, abs_diff;
  logic              a_gt_b, near;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < RESP_BITS; i++) begin
      if (bit_idx_q == BIT_W'(i)) begin
        sel_a = chal_q[i*2*SEL_W +: SEL_W];
        sel_b = chal_q[i*2*SEL_W+SEL_W +: SEL_W];
      end
    end
  end

  assign bank_a = ro_in[NUM_RO-1:0];
  assign bank_b = ro_in[2*NUM_RO-1:NUM_RO];

  // Bits [1:0] form the two-flop synchronizer; bit 2 is the previous synchronized value.
  assign sync_a_d = {sync_a_q[1:0], bank_a[sel_a]};
  assign sync_b_d = {sync_b_q[1:0], bank_b[sel_b]};
  assign pulse_a  = sync_a_q[1] & ~sync_a_q[2];
  assign pulse_b  = sync_b_q[1] & ~sync_b_q[2];

  assign cnt_a_x  = {1'b0, count_a_q};
  assign cnt_b_x  = {1'b0, count_b_q};
  assign a_gt_b   = count_a_q > count_b_q;
  assign abs_diff = a_gt_b ? (cnt_a_x - cnt_b_x) : (cnt_b_x - cnt_a_x);
  assign near     = abs_diff < MARGIN_X;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    chal_d    = chal_q;
    count_a_d = count_a_q;
    count_b_d = count_b_q;
    resp_d    = resp_q;
    unst_d    = unst_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETTLE;
          timer_d   = '0;
          bit_idx_d = '0;
          chal_d    = challenge;
          resp_d    = '0;
          unst_d    = '0;
        end
      end
      ST_SETTLE: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == SETTLE_LAST) begin
          state_d   = ST_COUNT;
          timer_d   = '0;
          count_a_d = '0;
          count_b_d = '0;
        end
      end
      ST_COUNT: begin
        timer_d = timer_q + 1'b1;
        if (pulse_a && (count_a_q != CNT_MAX)) count_a_d = count_a_q + 1'b1;
        if (pulse_b && (count_b_q != CNT_MAX)) count_b_d = count_b_q + 1'b1;
        if (timer_q == WINDOW_LAST) begin
          state_d = ST_COMPARE;
          timer_d = '0;
        end
      end
      ST_COMPARE: begin
        for (int i = 0; i < RESP_BITS; i++) begin
          if (bit_idx_q == BIT_W'(i)) begin
            resp_d[i] = a_gt_b;
            unst_d[i] = near;
          end
        end
        if (bit_idx_q == BIT_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d   = ST_SETTLE;
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      chal_q    <= '0;
      count_a_q <= '0;
      count_b_q <= '0;
      resp_q    <= '0;
      unst_q    <= '0;
      sync_a_q  <= '0;
      sync_b_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      chal_q    <= chal_d;
      count_a_q <= count_a_d;
      count_b_q <= count_b_d;
      resp_q    <= resp_d;
      unst_q    <= unst_d;
      sync_a_q  <= sync_a_d;
      sync_b_q  <= sync_b_d;
    end
  end

  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_COUNT) || (state_q == ST_COMPARE);
  assign ro_enable = busy;
  assign done      = (state_q == ST_DONE);
  assign response  = resp_q;
  assign unstable  = unst_q;

endmodule

// File: tb/tb_ro_puf_engine.sv
// tb/tb_ro_puf_engine.sv - scoreboard bench for ro_puf_engine
// Two instances share synthetic oscillator waveforms; the second uses 4-bit counters.
`timescale 1ns/1ps
module tb_ro_puf_engine;
  localparam int RB  = 2;
  localparam int NR  = 16;
  localparam int WIN = 64;
  localparam int SET = 4;
  localparam int LAT = RB * (SET + WIN + 1) + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_m = 1'b0, start_s = 1'b0;
  logic [15:0] chal_m = '0, chal_s = '0;
  logic [31:0] ro_in = '0;
  logic        en_m, busy_m, done_m, en_s, busy_s, done_s;
  logic [1:0]  resp_m, unst_m, resp_s, unst_s;

  int cyc = 0;
  int t_ph = 0;
  int tests = 0;
  int fails = 0;
  int per [8] = '{0, 2, 16, 4, 32, 8, 64, 4};

  typedef struct {
    logic [1:0] resp;
    logic [1:0] unst;
    int         acc;
  } exp_t;
  exp_t q_m[$];
  exp_t q_s[$];

  ro_puf_engine #(.NUM_RO(NR), .SEL_W(4), .RESP_BITS(RB), .CNT_W(16), .WINDOW(WIN),
                  .SETTLE(SET), .MARGIN(4)) dut_m (
    .clock(clock), .reset(reset), .start(start_m), .challenge(chal_m), .ro_in(ro_in),
    .ro_enable(en_m), .busy(busy_m), .done(done_m), .response(resp_m), .unstable(unst_m)
  );

  ro_puf_engine #(.NUM_RO(NR), .SEL_W(4), .RESP_BITS(RB), .CNT_W(4), .WINDOW(WIN),
                  .SETTLE(SET), .MARGIN(4)) dut_s (
    .clock(clock), .reset(reset), .start(start_s), .challenge(chal_s), .ro_in(ro_in),
    .ro_enable(en_s), .busy(busy_s), .done(done_s), .response(resp_s), .unstable(unst_s)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Channel k in both banks: square wave of period per[k] cycles (0 = stuck low).
  always @(negedge clock) begin
    t_ph = t_ph + 1;
    for (int k = 0; k < 8; k++) begin
      ro_in[k]      = (per[k] == 0) ? 1'b0 : ((t_ph % per[k]) < (per[k] / 2));
      ro_in[NR + k] = ro_in[k];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : mon_m
    exp_t e;
    if (!reset && done_m) begin
      if (q_m.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL m_unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        e = q_m.pop_front();
        check("m_response", resp_m, e.resp);
        check("m_unstable", unst_m, e.unst);
        check("m_latency", cyc - e.acc + 1, LAT);
      end
    end
  end

  always @(negedge clock) begin : mon_s
    exp_t e;
    if (!reset && done_s) begin
      if (q_s.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL s_unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        e = q_s.pop_front();
        check("s_response", resp_s, e.resp);
        check("s_unstable", unst_s, e.unst);
        check("s_latency", cyc - e.acc + 1, LAT);
      end
    end
  end

  task automatic push(input bit sat, input logic [1:0] er, input logic [1:0] eu);
    exp_t e;
    e.resp = er;
    e.unst = eu;
    e.acc  = cyc;
    if (sat) q_s.push_back(e);
    else     q_m.push_back(e);
  endtask

  // sel: 0 busy_m, 1 done_m, 2 busy_s, 3 done_s
  task automatic wait_for(input int sel, input int limit, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clock);
      case (sel)
        0: ok = busy_m;
        1: ok = done_m;
        2: ok = busy_s;
        default: ok = done_s;
      endcase
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s: got no event in %0d cycles, expected one", name, limit);
    end
  endtask

  task automatic eval_one(input bit sat, input logic [15:0] ch,
                          input logic [1:0] er, input logic [1:0] eu);
    @(negedge clock);
    if (sat) begin chal_s = ch; start_s = 1'b1; end
    else     begin chal_m = ch; start_m = 1'b1; end
    wait_for(sat ? 2 : 0, 8, "accept");
    push(sat, er, eu);
    start_m = 1'b0;
    start_s = 1'b0;
    wait_for(sat ? 3 : 1, LAT + 10, "done");
    @(negedge clock);
  endtask

  initial begin : stim
    int bad;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_ro_enable", {en_s, en_m}, 2'b00);
    check("rst_busy", {busy_s, busy_m}, 2'b00);
    check("rst_done", {done_s, done_m}, 2'b00);
    check("rst_response", {resp_s, resp_m}, 4'h0);
    check("rst_unstable", {unst_s, unst_m}, 4'h0);
    @(negedge clock);
    reset = 1'b0;

    eval_one(1'b0, 16'h3553, 2'b01, 2'b00);
    eval_one(1'b0, 16'h7373, 2'b00, 2'b11);
    eval_one(1'b0, 16'h5173, 2'b10, 2'b01);
    eval_one(1'b0, 16'h2402, 2'b01, 2'b10);
    eval_one(1'b1, 16'h6331, 2'b10, 2'b01);

    // start held high through two evaluations, challenge churning mid-run
    @(negedge clock);
    chal_m = 16'h3553;
    start_m = 1'b1;
    wait_for(0, 8, "t4_accept1");
    push(1'b0, 2'b01, 2'b00);
    repeat (60) begin
      @(negedge clock);
      chal_m = 16'($urandom);
    end
    chal_m = 16'h2402;
    wait_for(1, LAT + 10, "t4_done1");
    wait_for(0, 8, "t4_accept2");
    push(1'b0, 2'b01, 2'b10);
    start_m = 1'b0;
    chal_m = 16'h7373;
    wait_for(1, LAT + 10, "t4_done2");
    @(negedge clock);

    // reset in the middle of bit 1's counting window
    @(negedge clock);
    chal_m = 16'h3553;
    start_m = 1'b1;
    wait_for(0, 8, "t5_accept");
    start_m = 1'b0;
    repeat (SET + WIN + 1 + SET + 10) @(negedge clock);
    check("t5_resp_before_reset", resp_m, 2'b01);
    check("t5_busy_before_reset", busy_m, 1'b1);
    reset = 1'b1;
    #1;
    check("t5_rst_ro_enable", en_m, 1'b0);
    check("t5_rst_busy", busy_m, 1'b0);
    check("t5_rst_done", done_m, 1'b0);
    check("t5_rst_response", resp_m, 2'b00);
    check("t5_rst_unstable", unst_m, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    eval_one(1'b0, 16'h3553, 2'b01, 2'b00);

    bad = 0;
    repeat (200) begin
      @(negedge clock);
      if (en_m || busy_m || done_m || (resp_m !== 2'b01) || (unst_m !== 2'b00)) bad++;
    end
    check("t6_idle_violations", bad, 0);

    repeat (5) @(negedge clock);
    check("pending_expectations", q_m.size() + q_s.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ro_puf_engine.md
Name: ro_puf_engine

Overview:
- Parametrised, sequenced ring-oscillator PUF evaluator; replaces the free-running race arbiter with a counting-window scheme.
- For each of RESP_BITS response bits it selects one oscillator from bank A and one from bank B using challenge fields, counts rising edges of each over a fixed clock window, and compares the counts.
- Adds start/busy/done handshake, settle period, per-bit instability flags and saturating counters.
- Sits between the oscillator arrays (external; ro_in) and the host interface.

Parameters:
- NUM_RO, 16, oscillators per bank (power of two, >=2).
- SEL_W, 4, log2(NUM_RO).
- RESP_BITS, 8, response bits produced per evaluation.
- CNT_W, 16, edge counter width.
- WINDOW, 1024, counting window length in clock cycles (>=1).
- SETTLE, 16, cycles oscillators run before counting (>=1).
- MARGIN, 4, minimum |count_a - count_b| for a bit to be stable.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request an evaluation; sampled only in IDLE.
- challenge  in  RESP_BITS*2*SEL_W  for bit i: sel_a = [i*2*SEL_W +: SEL_W], sel_b = [i*2*SEL_W+SEL_W +: SEL_W].
- ro_in  in  2*NUM_RO  raw oscillator outputs; [NUM_RO-1:0] is bank A, upper half is bank B; asynchronous to clock.
- ro_enable  out  1  enable to all oscillators.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle pulse when response/unstable are valid.
- response  out  RESP_BITS  response word.
- unstable  out  RESP_BITS  bit i = 1 if bit i was within MARGIN.

Behaviour:
- Reset (async assert, sync release): state IDLE; ro_enable=0, busy=0, done=0, response=0, unstable=0, counters=0, bit index=0.
- challenge is registered when start is accepted. Later challenge changes do not affect the running evaluation.
- Input path: both selected oscillators go through the 16:1 muxes, then a 2-flop synchronizer, then a rising-edge detector (one pulse per 0->1 of the synchronized signal).
  - Sources must toggle slower than clock/2; faster sources are out of scope.
- FSM:
  - IDLE: start=1 -> SETTLE; set busy=1, ro_enable=1, bit index=0, clear response and unstable.
  - SETTLE: lasts exactly SETTLE cycles, with mux selects set for the current bit. Counters are cleared on the last cycle. Then -> COUNT.
  - COUNT: lasts exactly WINDOW cycles. count_a and count_b increment on their edge pulses and saturate at 2^CNT_W-1 (no wrap). Then -> COMPARE.
  - COMPARE (1 cycle):
    - response[i] = (count_a > count_b).
    - unstable[i] = (|count_a - count_b| < MARGIN), computed with CNT_W+1-bit arithmetic.
    - Tie: response[i]=0, unstable[i]=1 (for MARGIN>=1).
    - If i == RESP_BITS-1 -> DONE; else i+1 -> SETTLE.
  - DONE (1 cycle): done=1, busy=0, ro_enable=0 -> IDLE.
- Latency: from the start-accept edge to the done pulse is RESP_BITS*(SETTLE+WINDOW+1)+1 cycles.
- Output holding:
  - response and unstable hold their values after done until the next accepted start.
  - ro_enable is high from SETTLE through COMPARE of the last bit.
- start while busy is ignored, with no queuing. start held high in IDLE after DONE begins a new evaluation.
- Edge pulses arriving outside COUNT are not counted. Synchronizer latency (2 cycles) is part of the design and is not compensated.
- Reset mid-operation aborts immediately to the reset values. No done pulse is issued.

Test Plan:
- Params WINDOW=64, SETTLE=4, RESP_BITS=2, MARGIN=4.
  - Stimulus: ro_in bank A ch3 as a period-4 square wave, bank B ch5 at period 8, challenge bit0 fields sel_a=3, sel_b=5; bit1 reversed pair.
  - Expected: done at 2*69+1=139 cycles after start; response=2'b01; unstable=2'b00; count_a=16, count_b=8 for bit0.
- Same sources, both selects pointing at identical-period channels (period 4).
  - Expected: counts 16/16; response bit=0; unstable bit=1.
- CNT_W=4, WINDOW=64, source period 2 vs period 4.
  - Expected: both counters saturate at 15; response=0, unstable=1 (tie after saturation).
- Pulse start every cycle during an evaluation, and change challenge mid-run.
  - Expected: exactly one done per evaluation at the computed latency; response matches the challenge captured at accept.
- Assert reset during COUNT of bit 1.
  - Expected: all outputs 0 on the same cycle (async), no done.
  - A new start after release yields a correct full evaluation.
- Idle, no start for 200 cycles.
  - Expected: ro_enable=0, busy=0, done never asserted, response stable at its last value.
